// File: rtl/wb_pkg.sv
// Shared widths, register-file constants and the write-back request type.
// No logic of its own; the helpers are pure combinational functions.
// Imported by the load FIFO and the write-back/scoreboard top level.
package wb_pkg;

    localparam int DATA_W   = 19;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 15;

    // r15 reads as PC+8; it has no storage, is never written and never busy
    localparam logic [ADDR_W-1:0] PC_REG = 4'hF;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Busy lookup that treats the PC alias as permanently ready
    function automatic logic reg_busy(input logic [NUM_REGS-1:0] busy,
                                      input logic [ADDR_W-1:0]   idx);
        logic res;
        res = 1'b0;
        if (idx != PC_REG) begin
            res = busy[idx];
        end
        return res;
    endfunction

    // One-hot register mask; the PC alias maps to an empty mask
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [ADDR_W-1:0] idx);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (idx != PC_REG) begin
            m[idx] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests (load results awaiting the write port).
// Latency: a pushed entry is visible at the head in the cycle after the push.
// Backpressure: full_o is driven from the registered count, pushes while full are ignored.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push_i,
    input  logic    pop_i,
    input  wb_req_t wdata_i,
    output wb_req_t rdata_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t       mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rptr_q];

    // Guard the handshakes locally so a careless caller cannot corrupt the count
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next state; pointers wrap naturally at DEPTH (power of two)
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count state; reset discards anything buffered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array carries no reset: occupancy alone says what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Write-back arbiter (ALU over buffered loads) with register busy scoreboard and decode stall.
// Latency: ALU result -> we3 next cycle; load -> we3 two cycles after acceptance when uncontested.
// Backpressure: ALU always accepted; loads flow-controlled by ld_ready (FIFO not full).
module wb_scoreboard #(
    parameter int DATA_W     = 19,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_valid,
    input  logic              iss_wr,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] iss_ra1,
    input  logic [ADDR_W-1:0] iss_ra2,
    output logic              stall,
    output logic [14:0]       busy,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3
);

    import wb_pkg::*;

    wb_req_t             ld_req;
    wb_req_t             fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;

    wb_req_t             sel_req;
    logic                sel_vld;

    logic                we3_q, we3_d;
    logic [ADDR_W-1:0]   wa3_q, wa3_d;
    logic [DATA_W-1:0]   wd3_q, wd3_d;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic                iss_accept;

    // Load side: accept whenever there is room; nothing is taken while reset is held
    assign ld_ready   = !fifo_full && !reset;
    assign fifo_push  = ld_valid && ld_ready;
    assign ld_req.rd   = ld_rd;
    assign ld_req.data = ld_data;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_ld_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (ld_req),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Write-port arbitration: ALU has strict priority, otherwise drain one buffered load
    always_comb begin
        sel_vld  = 1'b0;
        sel_req  = '0;
        fifo_pop = 1'b0;
        if (alu_valid) begin
            sel_vld      = 1'b1;
            sel_req.rd   = alu_rd;
            sel_req.data = alu_data;
        end else if (!fifo_empty) begin
            sel_vld  = 1'b1;
            sel_req  = fifo_head;
            fifo_pop = 1'b1;
        end
    end

    // Output register next state; a PC-alias result is consumed but never written
    always_comb begin
        we3_d = sel_vld && (sel_req.rd != PC_REG);
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (we3_d) begin
            wa3_d = sel_req.rd;
            wd3_d = sel_req.data;
        end
    end

    // Register-file write port, held stable for the whole write cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we3_q <= 1'b0;
            wa3_q <= '0;
            wd3_q <= '0;
        end else begin
            we3_q <= we3_d;
            wa3_q <= wa3_d;
            wd3_q <= wd3_d;
        end
    end

    assign we3 = we3_q;
    assign wa3 = wa3_q;
    assign wd3 = wd3_q;

    // Decode hazard check against pending writes (RAW on either source, WAW on dest)
    always_comb begin
        stall = iss_valid && (reg_busy(busy_q, iss_ra1) ||
                              reg_busy(busy_q, iss_ra2) ||
                              (iss_wr && reg_busy(busy_q, iss_rd)));
    end

    assign iss_accept = iss_valid && iss_wr && !stall;

    // Scoreboard next state: clear on the edge the write is registered, new issue wins a tie
    always_comb begin
        set_mask = iss_accept ? reg_mask(iss_rd) : '0;
        clr_mask = we3_d ? reg_mask(sel_req.rd) : '0;
        busy_d   = (busy_q & ~clr_mask) | set_mask;
    end

    // Pending-write flags; reset drops all outstanding destinations
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

Write-back unit and register scoreboard sitting between the execute/memory stages and the 15-entry, 19-bit register file. It merges single-cycle ALU results and multi-cycle load results onto the register file's one write port. It buffers loads in a small FIFO and tracks pending destination registers so decode stalls on RAW/WAW hazards. Register 15 is the PC+8 alias: it is never written and is never busy.

## Interface
Parameters:
- DATA_W, 19, register data width
- ADDR_W, 4, register address width
- FIFO_DEPTH, 4, load-result buffer entries (power of two)

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- iss_valid  in  1  decode presents an instruction
- iss_wr  in  1  that instruction writes a destination register
- iss_rd  in  ADDR_W  destination register
- iss_ra1, iss_ra2  in  ADDR_W  source registers
- stall  out  1  combinational; decode must hold
- busy  out  15  per-register pending-write flags (r0..r14)
- alu_valid  in  1  ALU result present this cycle (always accepted)
- alu_rd  in  ADDR_W; alu_data  in  DATA_W
- ld_valid  in  1  load result offered
- ld_ready  out  1  load result accepted when ld_valid && ld_ready
- ld_rd  in  ADDR_W; ld_data  in  DATA_W
- we3  out  1  register-file write enable (registered)
- wa3  out  ADDR_W  write address (registered)
- wd3  out  DATA_W  write data (registered)

## Operation
- Load FIFO:
  - ld_ready = !full.
  - A handshake pushes {ld_rd, ld_data} at the posedge.
  - Read and write pointers wrap mod FIFO_DEPTH.
  - The count spans 0..FIFO_DEPTH.
  - Push and pop in the same cycle are legal when not empty, and leave the count unchanged.
- Write-port arbitration, each cycle:
  - If alu_valid, select the ALU result.
  - Otherwise, if the FIFO is not empty, pop the head and select it.
  - Otherwise, select nothing.
  - At the posedge, the selection loads we3/wa3/wd3; we3=0 when nothing is selected.
  - ALU has strict priority. A load waiting behind continuous ALU traffic waits indefinitely; this is accepted.
- r15 writes: a selected entry with rd==15 is consumed (FIFO popped or ALU taken) but drives we3=0. Loads to r15 are still accepted.
- Scoreboard:
  - Set busy[iss_rd] at the posedge when iss_valid && iss_wr && !stall && iss_rd!=15.
  - Clear busy[wa] at the posedge where a write with address wa loads into the output register. This is the same edge we3 rises.
  - If set and clear hit the same register on the same edge, set wins. The WAW stall makes this unreachable in legal use.
  - A write to a non-busy register is performed, and its busy flag stays 0.
- stall = iss_valid && (busy[iss_ra1] || busy[iss_ra2] || (iss_wr && busy[iss_rd])). Index 15 always reads as not busy.

## Timing
- Reset values:
  - we3=0, wa3=0, wd3=0.
  - busy=0, FIFO empty, so stall=0 whenever iss_valid=0.
  - ld_ready=1 once reset deasserts; it is 0 while reset is high.
- Reset mid-operation: buffered loads and pending busy flags are discarded immediately.
- ALU latency: a result present in cycle N gives we3=1 during cycle N+1. The register file writes at the negedge of N+1. busy clears at the N+1 posedge, so decode reads the new value in N+1 with stall low.
- Load latency:
  - A load accepted at the posedge ending cycle N pops no earlier than cycle N+1.
  - we3 goes high in N+2 when no ALU result competes.
  - Each competing ALU cycle delays it by one.
- Throughput: one register-file write per cycle.
- Full FIFO: ld_ready=0 for the full cycle. It rises in the cycle after a pop.

## Structure
- Package wb_pkg holds:
  - DATA_W, ADDR_W, PC_REG = 4'hF
  - typedef wb_req_t = struct {rd, data}
- Sub-module wb_fifo: parameterised synchronous FIFO of wb_req_t with push/pop, full/empty and count.
- The top level contains the arbiter, output register, scoreboard flops and stall logic.

## Test plan
- Reset then idle:
  - Apply reset mid-stream with 2 loads buffered.
  - Require we3=0, busy=0 and ld_ready=1 after release.
  - Require that no buffered load is ever written.
- ALU hazard:
  - Issue rd=3, then ALU result r3=19'h1234 in cycle N.
  - Require we3=1, wa3=3, wd3=19'h1234 in N+1.
  - Require that source ra1=3 stalls in N and is released in N+1.
- Load FIFO full:
  - Hold alu_valid high and push 4 loads.
  - Require ld_ready=0.
  - After dropping alu_valid, require 4 writes in push order, then ld_ready=1.
- Collision: alu_valid and a buffered load in the same cycle; require the ALU write first and the load one cycle later.
- r15 handling:
  - Send a load to rd=15 with data 19'h7FFFF; require it to be accepted, then popped with we3=0.
  - Issue with iss_rd=15; require busy unchanged and no stall.
- WAW: with r5 busy, issue another rd=5 write; require stall=1 until r5's write, then issue and busy[5] set again.
